// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle RISC-V core: byte/half/word loads
// and stores with a fixed wait-state latency, alignment checking and a ready pulse.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        misaligned
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, state_nxt;

    logic [3:0]    cnt;
    logic          q_write, q_err;
    logic [2:0]    q_f3;
    logic [AW+1:0] q_addr;
    logic [31:0]   q_wdata;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          req, c_write, c_legal, commit;
    logic [2:0]    c_f3;
    logic [AW+1:0] c_addr;
    logic [31:0]   c_wdata, word, shifted, ld_val, st_data;
    logic [3:0]    st_be;

    assign req = mem_read | mem_write;

    // The access being decided: live inputs on the accept edge, captured copy afterwards,
    // so a zero-wait access can commit on the same edge it is accepted.
    always_comb begin
        if (state == IDLE) begin
            c_write = mem_write;
            c_f3    = funct3;
            c_addr  = addr[AW+1:0];
            c_wdata = wdata;
        end else begin
            c_write = q_write;
            c_f3    = q_f3;
            c_addr  = q_addr;
            c_wdata = q_wdata;
        end
    end

    always_comb begin
        c_legal = 1'b0;
        case (c_f3)
            3'b000, 3'b100: c_legal = !(c_f3[2] && c_write);
            3'b001, 3'b101: c_legal = !c_addr[0] && !(c_f3[2] && c_write);
            3'b010:         c_legal = (c_addr[1:0] == 2'b00);
            default:        c_legal = 1'b0;
        endcase
    end

    assign commit = (state == IDLE && req && c_legal && WAIT_CYCLES == 0) ||
                    (state == WAIT && cnt == 4'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) state_nxt = (c_legal && WAIT_CYCLES > 0) ? WAIT : DONE;
            WAIT: if (cnt == 4'd0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign ready      = (state == DONE);
    assign misaligned = ready & q_err;

    // Load path: pick the addressed byte/half, then extend.
    always_comb begin
        word    = mem[c_addr[AW+1:2]];
        shifted = word >> {c_addr[1:0], 3'b000};
        case (c_f3[1:0])
            2'b00:   ld_val = {{24{!c_f3[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   ld_val = {{16{!c_f3[2] & shifted[15]}}, shifted[15:0]};
            default: ld_val = word;
        endcase
    end

    // Store path: replicate right-aligned data across lanes, enable only addressed bytes.
    always_comb begin
        case (c_f3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << c_addr[1:0];
                st_data = {4{c_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = c_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{c_wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = c_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            q_write <= 1'b0;
            q_err   <= 1'b0;
            q_f3    <= 3'd0;
            q_addr  <= '0;
            q_wdata <= 32'd0;
            rdata   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                q_write <= mem_write;
                q_f3    <= funct3;
                q_addr  <= addr[AW+1:0];
                q_wdata <= wdata;
                q_err   <= !c_legal;
                cnt     <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && !c_write) rdata <= ld_val;
        end
    end

    // Array is not reset; rst_n gating keeps a held strobe from writing during reset.
    always_ff @(posedge clk) begin
        if (commit && c_write && rst_n) begin
            for (int i = 0; i < 4; i++)
                if (st_be[i]) mem[c_addr[AW+1:2]][8*i +: 8] <= st_data[8*i +: 8];
        end
    end

    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW+2];
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the single-cycle RISC-V core. Sits on the far side of the load/store control strobes (mem_read, mem_write) and funct3 produced by the control unit.
- Accepts one byte, half or word access at a time and applies a configurable wait-state latency.
- Performs alignment checking and byte-lane merging on stores, and sign/zero extension on loads.
- Signals completion with a one-cycle ready pulse, so the core can be stalled while an access is outstanding.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words stored. Power of two, at least 4.
- WAIT_CYCLES, 2: wait states between accept and completion. Range 0 to 15.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- mem_read, input, 1: load request strobe.
- mem_write, input, 1: store request strobe.
- funct3, input, 3: access size and sign (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU).
- addr, input, 32: byte address.
- wdata, input, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata, output, 32: extended load result.
- ready, output, 1: one-cycle completion pulse.
- busy, output, 1: high while an access is outstanding.
- misaligned, output, 1: error flag, valid with ready.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; ready=0, busy=0, misaligned=0, rdata=0.
  - Memory array contents are not reset.
  - Asserting reset mid-access aborts the access. A store not yet committed is never written.
- States: IDLE, WAIT, DONE. busy = (state != IDLE).
- IDLE:
  - On a clock edge with mem_read or mem_write high, capture addr, wdata, funct3 and the operation.
  - If both strobes are high, treat as a store.
  - Next state is WAIT if the access is legal and WAIT_CYCLES > 0. Otherwise next state is DONE.
- Legality (checked on captured values):
  - funct3 011, 110 or 111: illegal for loads and stores.
  - funct3 100 or 101 with a store: illegal.
  - Half access with addr[0]=1: illegal.
  - Word access with addr[1:0] != 00: illegal.
- WAIT:
  - A down-counter loaded with WAIT_CYCLES-1 decrements each cycle.
  - At zero, go to DONE.
- Store commit:
  - On the edge that enters DONE, write only the addressed byte lanes.
  - Word index is addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored (wraps modulo DEPTH_WORDS).
  - Lane mapping: byte lane = addr[1:0]; half lanes = addr[1]*2 and addr[1]*2+1.
  - Unaddressed bytes are unchanged.
- Load result:
  - On the edge that enters DONE, rdata is loaded with the selected byte or half.
  - Sign-extended for funct3[2]=0, zero-extended for funct3[2]=1.
  - Word loads pass through unchanged.
  - rdata holds its value until the next successful load completes. Stores and errors do not change it.
- DONE:
  - ready=1 for exactly one cycle. Next state is IDLE.
  - misaligned=1 in that cycle for an illegal access, otherwise 0. misaligned is 0 whenever ready is 0.
  - An illegal access performs no memory write and leaves rdata unchanged. It skips WAIT and always completes in DONE at 1 cycle.
- Latency:
  - Request sampled at edge N gives ready high during cycle N+WAIT_CYCLES+1.
  - Throughput is one access per WAIT_CYCLES+2 cycles.
- Requests presented while busy=1 (including the DONE cycle) are ignored and not queued. The core holds its strobes until ready.
- Read-after-write to the same address in back-to-back accesses returns the newly written data.

Test Plan:
- Reset, then SW 0xDEADBEEF at addr 0x10, then LW 0x10, WAIT_CYCLES=2 → each ready pulses 3 cycles after accept; busy high 3 cycles; rdata=0xDEADBEEF, misaligned=0.
- SW 0x11223344 at 0x20, then SB 0xAA at 0x22 → LW 0x20 returns 0x11AA3344. Then LB 0x22 returns 0xFFFFFFAA and LBU 0x22 returns 0x000000AA.
- SH 0x8001 at 0x32, then LH 0x32 → 0xFFFF8001. LHU 0x32 → 0x00008001. LW 0x30 upper half = 0x8001.
- LW at 0x41, SH at 0x43, funct3=011, SBU (store with funct3=100) → ready at 1 cycle after accept with misaligned=1; memory at 0x40 unchanged; rdata keeps its prior value.
- Issue SW to 0x50, assert rst_n=0 during WAIT, release, then LW 0x50 → old contents of 0x50 returned; ready/busy/misaligned all 0 during reset.
- WAIT_CYCLES=0, DEPTH_WORDS=256: SW 0x5 to addr 0x400, then LW addr 0x0 → ready 1 cycle after each accept; rdata=0x5 (wrap-around); new strobes asserted during the DONE cycle are ignored.
